// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - single-frame buffer: raster LOAD, coordinate PROC, VGA DISPLAY
// One simple-dual-port RAM; the write and read ports are each muxed by the phase FSM.
module frame_buffer_ctrl #(
  parameter int PIX_W   = 8,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int ADDR_W  = 19,
  parameter int COORD_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [PIX_W-1:0]   pix_in_i,
  input  logic               pix_in_valid_i,
  input  logic               proc_rd_req_i,
  input  logic [COORD_W-1:0] proc_rd_x_i,
  input  logic [COORD_W-1:0] proc_rd_y_i,
  output logic [PIX_W-1:0]   proc_rd_data_o,
  output logic               proc_rd_valid_o,
  input  logic               proc_wr_valid_i,
  input  logic [COORD_W-1:0] proc_wr_x_i,
  input  logic [COORD_W-1:0] proc_wr_y_i,
  input  logic [PIX_W-1:0]   proc_wr_data_i,
  input  logic               proc_done_i,
  input  logic [COORD_W-1:0] vga_x_i,
  input  logic [COORD_W-1:0] vga_y_i,
  output logic [PIX_W-1:0]   vga_rd_data_o,
  output logic               vga_rd_valid_o,
  input  logic               frame_restart_i,
  output logic               load_done_o,
  output logic [1:0]         state_o,
  output logic               oob_err_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_W * FRAME_H - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_PROC = 2'b01,
    ST_DISP = 2'b10
  } state_e;

  // Low ADDR_W bits of y*FRAME_W+x; modular arithmetic gives the truncated address directly.
  function automatic logic [ADDR_W-1:0] xy_addr(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(FRAME_W) + ADDR_W'(x);
  endfunction

  function automatic logic in_range(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y);
    return (int'(x) < FRAME_W) && (int'(y) < FRAME_H);
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
  logic              load_done_q, load_done_d;
  logic              oob_err_q, oob_err_d;
  logic              proc_rd_valid_q, proc_rd_valid_d;
  logic              vga_rd_valid_q, vga_rd_valid_d;
  logic              rd_zero_q, rd_zero_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [PIX_W-1:0]  wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] raddr;

  logic [PIX_W-1:0]  mem [DEPTH];
  logic [PIX_W-1:0]  ram_rd_q;

  always_comb begin
    state_d         = state_q;
    load_cnt_d      = load_cnt_q;
    load_done_d     = load_done_q;
    oob_err_d       = oob_err_q;
    proc_rd_valid_d = 1'b0;
    vga_rd_valid_d  = 1'b0;
    rd_zero_d       = 1'b0;
    we              = 1'b0;
    waddr           = '0;
    wdata           = '0;
    rd_en           = 1'b0;
    raddr           = '0;

    unique case (state_q)
      ST_LOAD: begin
        if (pix_in_valid_i) begin
          we         = 1'b1;
          waddr      = load_cnt_q;
          wdata      = pix_in_i;
          load_cnt_d = load_cnt_q + ADDR_W'(1);
          if (load_cnt_q == LAST_PIX) begin
            state_d     = ST_PROC;
            load_done_d = 1'b1;
          end
        end
      end
      ST_PROC: begin
        if (proc_wr_valid_i) begin
          if (in_range(proc_wr_x_i, proc_wr_y_i)) begin
            we    = 1'b1;
            waddr = xy_addr(proc_wr_x_i, proc_wr_y_i);
            wdata = proc_wr_data_i;
          end else begin
            oob_err_d = 1'b1;
          end
        end
        if (proc_rd_req_i) begin
          rd_en           = 1'b1;
          raddr           = xy_addr(proc_rd_x_i, proc_rd_y_i);
          proc_rd_valid_d = 1'b1;
          if (!in_range(proc_rd_x_i, proc_rd_y_i)) begin
            rd_zero_d = 1'b1;
            oob_err_d = 1'b1;
          end
        end
        if (proc_done_i) begin
          state_d = ST_DISP;
        end
      end
      ST_DISP: begin
        // Out-of-range display coordinates are blanking, not an error.
        rd_en          = 1'b1;
        raddr          = xy_addr(vga_x_i, vga_y_i);
        vga_rd_valid_d = 1'b1;
        rd_zero_d      = !in_range(vga_x_i, vga_y_i);
        if (frame_restart_i) begin
          state_d     = ST_LOAD;
          load_cnt_d  = '0;
          load_done_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ST_LOAD;
      load_cnt_q      <= '0;
      load_done_q     <= 1'b0;
      oob_err_q       <= 1'b0;
      proc_rd_valid_q <= 1'b0;
      vga_rd_valid_q  <= 1'b0;
      rd_zero_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      load_cnt_q      <= load_cnt_d;
      load_done_q     <= load_done_d;
      oob_err_q       <= oob_err_d;
      proc_rd_valid_q <= proc_rd_valid_d;
      vga_rd_valid_q  <= vga_rd_valid_d;
      rd_zero_q       <= rd_zero_d;
    end
  end

  // Read and write in one process: a same-address read returns the pre-write word.
  always_ff @(posedge clk_i) begin
    if (we && !reset_i) begin
      mem[waddr] <= wdata;
    end
    if (rd_en) begin
      ram_rd_q <= mem[raddr];
    end
  end

  assign proc_rd_valid_o = proc_rd_valid_q;
  assign vga_rd_valid_o  = vga_rd_valid_q;
  assign proc_rd_data_o  = (proc_rd_valid_q && !rd_zero_q) ? ram_rd_q : '0;
  assign vga_rd_data_o   = (vga_rd_valid_q && !rd_zero_q) ? ram_rd_q : '0;
  assign load_done_o     = load_done_q;
  assign state_o         = state_q;
  assign oob_err_o       = oob_err_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb/tb_frame_buffer_ctrl.sv - self-checking bench for frame_buffer_ctrl
// Reduced 40x30 frame; a plain pixel array models the frame contents.
module tb_frame_buffer_ctrl;
  localparam int PW = 8;
  localparam int FW = 40;
  localparam int FH = 30;
  localparam int AW = 11;
  localparam int CW = 16;
  localparam int NPIX = FW * FH;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pix_in;
  logic          pix_in_valid;
  logic          proc_rd_req;
  logic [CW-1:0] proc_rd_x, proc_rd_y;
  logic [PW-1:0] proc_rd_data;
  logic          proc_rd_valid;
  logic          proc_wr_valid;
  logic [CW-1:0] proc_wr_x, proc_wr_y;
  logic [PW-1:0] proc_wr_data;
  logic          proc_done;
  logic [CW-1:0] vga_x, vga_y;
  logic [PW-1:0] vga_rd_data;
  logic          vga_rd_valid;
  logic          frame_restart;
  logic          load_done;
  logic [1:0]    state;
  logic          oob_err;

  frame_buffer_ctrl #(
    .PIX_W(PW), .FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW), .COORD_W(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .pix_in_i(pix_in), .pix_in_valid_i(pix_in_valid),
    .proc_rd_req_i(proc_rd_req), .proc_rd_x_i(proc_rd_x), .proc_rd_y_i(proc_rd_y),
    .proc_rd_data_o(proc_rd_data), .proc_rd_valid_o(proc_rd_valid),
    .proc_wr_valid_i(proc_wr_valid), .proc_wr_x_i(proc_wr_x), .proc_wr_y_i(proc_wr_y),
    .proc_wr_data_i(proc_wr_data), .proc_done_i(proc_done),
    .vga_x_i(vga_x), .vga_y_i(vga_y),
    .vga_rd_data_o(vga_rd_data), .vga_rd_valid_o(vga_rd_valid),
    .frame_restart_i(frame_restart), .load_done_o(load_done),
    .state_o(state), .oob_err_o(oob_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [NPIX];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pix_in_valid = 0; pix_in = '0;
    proc_rd_req = 0; proc_rd_x = '0; proc_rd_y = '0;
    proc_wr_valid = 0; proc_wr_x = '0; proc_wr_y = '0; proc_wr_data = '0;
    proc_done = 0; vga_x = '0; vga_y = '0; frame_restart = 0;
  endtask

  // Streams n pixels of value (i*mul ^ xr) mod 256; a full frame also checks completion timing.
  task automatic load_pixels(input int n, input int mul, input int xr);
    for (int i = 0; i < n; i++) begin
      pix_in       = 8'((i * mul) ^ xr);
      pix_in_valid = 1;
      ref_mem[i]   = pix_in;
      if (i == NPIX - 1) begin
        chk("load_done_early", {31'b0, load_done}, 0);
        chk("state_early", {30'b0, state}, 0);
      end
      step();
    end
    pix_in_valid = 0;
    if (n == NPIX) begin
      chk("load_done_set", {31'b0, load_done}, 1);
      chk("state_proc", {30'b0, state}, 1);
    end
  endtask

  task automatic proc_read(input string tag, input int x, input int y, input logic [7:0] exp);
    proc_rd_req = 1; proc_rd_x = CW'(x); proc_rd_y = CW'(y);
    step();
    proc_rd_req = 0;
    chk({tag, "_valid"}, {31'b0, proc_rd_valid}, 1);
    chk({tag, "_data"}, {24'b0, proc_rd_data}, {24'b0, exp});
  endtask

  int rx, ry, wx, wy;
  logic rq, wv, exp_v;
  logic [7:0] wd, exp_d;

  initial begin
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    chk("rst_state", {30'b0, state}, 0);
    chk("rst_load_done", {31'b0, load_done}, 0);
    chk("rst_oob", {31'b0, oob_err}, 0);
    chk("rst_proc_valid", {31'b0, proc_rd_valid}, 0);
    chk("rst_vga_valid", {31'b0, vga_rd_valid}, 0);
    chk("rst_proc_data", {24'b0, proc_rd_data}, 0);
    chk("rst_vga_data", {24'b0, vga_rd_data}, 0);

    load_pixels(NPIX, 1, 0);

    // Camera pixels must not reach the RAM outside LOAD.
    pix_in_valid = 1; pix_in = 8'h55;
    step();
    pix_in_valid = 0;
    chk("no_read_valid", {31'b0, proc_rd_valid}, 0);

    proc_read("rd32", 3, 2, ref_mem[2*FW+3]);
    step();
    chk("rd_valid_drop", {31'b0, proc_rd_valid}, 0);

    proc_wr_valid = 1; proc_wr_x = 3; proc_wr_y = 2; proc_wr_data = 8'hAA;
    proc_read("rd_first", 3, 2, ref_mem[2*FW+3]);
    proc_wr_valid = 0;
    ref_mem[2*FW+3] = 8'hAA;
    proc_read("rd_after_wr", 3, 2, 8'hAA);
    proc_read("rd_pix0", 0, 0, ref_mem[0]);
    chk("oob_clear", {31'b0, oob_err}, 0);

    proc_wr_valid = 1; proc_wr_x = CW'(FW); proc_wr_y = 0; proc_wr_data = 8'h11;
    step();
    proc_wr_valid = 0;
    chk("oob_wr_set", {31'b0, oob_err}, 1);
    proc_read("oob_wr_alias", 0, 1, ref_mem[FW]);
    chk("oob_sticky", {31'b0, oob_err}, 1);
    proc_read("oob_rd", 0, FH, 8'h00);

    for (int k = 0; k < 200; k++) begin
      rq = 1'($urandom_range(0, 1));
      wv = 1'($urandom_range(0, 1));
      rx = ($urandom_range(0, 9) == 0) ? FW + int'($urandom_range(0, 3)) : int'($urandom_range(0, FW - 1));
      ry = ($urandom_range(0, 9) == 0) ? FH + int'($urandom_range(0, 3)) : int'($urandom_range(0, FH - 1));
      if ($urandom_range(0, 3) == 0) begin
        wx = rx; wy = ry;
      end else begin
        wx = int'($urandom_range(0, FW - 1)); wy = int'($urandom_range(0, FH - 1));
      end
      wd = 8'($urandom);
      exp_v = rq;
      exp_d = (rx < FW && ry < FH) ? ref_mem[ry*FW+rx] : 8'h00;
      if (wv && wx < FW && wy < FH) ref_mem[wy*FW+wx] = wd;
      proc_rd_req = rq; proc_rd_x = CW'(rx); proc_rd_y = CW'(ry);
      proc_wr_valid = wv; proc_wr_x = CW'(wx); proc_wr_y = CW'(wy); proc_wr_data = wd;
      step();
      chk("rand_proc_valid", {31'b0, proc_rd_valid}, {31'b0, exp_v});
      if (exp_v) chk("rand_proc_data", {24'b0, proc_rd_data}, {24'b0, exp_d});
    end

    // proc_done together with a write and a read: write lands, read trails into DISPLAY.
    exp_d = ref_mem[5*FW+5];
    proc_wr_valid = 1; proc_wr_x = 5; proc_wr_y = 5; proc_wr_data = 8'h3C;
    proc_rd_req = 1; proc_rd_x = 5; proc_rd_y = 5; proc_done = 1;
    step();
    ref_mem[5*FW+5] = 8'h3C;
    idle_inputs();
    chk("state_disp", {30'b0, state}, 2);
    chk("trail_valid", {31'b0, proc_rd_valid}, 1);
    chk("trail_data", {24'b0, proc_rd_data}, {24'b0, exp_d});

    proc_rd_req = 1; proc_wr_valid = 1; proc_wr_x = 0; proc_wr_y = 0; proc_wr_data = 8'hEE;
    vga_x = 5; vga_y = 5;
    step();
    idle_inputs();
    chk("proc_valid_disp", {31'b0, proc_rd_valid}, 0);
    chk("vga_valid", {31'b0, vga_rd_valid}, 1);
    chk("vga_done_wr", {24'b0, vga_rd_data}, 8'h3C);

    for (int x = 0; x < 4; x++) begin
      vga_x = CW'(x); vga_y = 0;
      step();
      chk("vga_sweep", {24'b0, vga_rd_data}, {24'b0, ref_mem[x]});
    end
    vga_x = CW'(FW); vga_y = 0;
    step();
    chk("vga_blank_valid", {31'b0, vga_rd_valid}, 1);
    chk("vga_blank_data", {24'b0, vga_rd_data}, 0);
    chk("vga_oob_unchanged", {31'b0, oob_err}, 1);

    for (int k = 0; k < 60; k++) begin
      rx = int'($urandom_range(0, FW + 2));
      ry = int'($urandom_range(0, FH + 2));
      exp_d = (rx < FW && ry < FH) ? ref_mem[ry*FW+rx] : 8'h00;
      vga_x = CW'(rx); vga_y = CW'(ry);
      step();
      chk("rand_vga", {24'b0, vga_rd_data}, {24'b0, exp_d});
    end

    frame_restart = 1;
    step();
    frame_restart = 0;
    chk("restart_state", {30'b0, state}, 0);
    chk("restart_load_done", {31'b0, load_done}, 0);
    chk("restart_trail_vga", {31'b0, vga_rd_valid}, 1);
    step();
    chk("load_vga_idle", {31'b0, vga_rd_valid}, 0);

    load_pixels(1000, 1, 8'h5A);
    reset = 1;
    step();
    reset = 0;
    chk("midrst_state", {30'b0, state}, 0);
    chk("midrst_oob", {31'b0, oob_err}, 0);
    chk("midrst_load_done", {31'b0, load_done}, 0);
    load_pixels(NPIX, 3, 0);
    proc_read("reload_pix0", 0, 0, ref_mem[0]);
    proc_read("reload_pix999", 999 % FW, 999 / FW, ref_mem[999]);
    proc_read("reload_pix1000", 1000 % FW, 1000 / FW, ref_mem[1000]);

    proc_rd_req = 1; proc_rd_x = 1; proc_rd_y = 1; reset = 1;
    step();
    reset = 0; proc_rd_req = 0;
    chk("rst_drop_valid", {31'b0, proc_rd_valid}, 0);
    chk("rst_drop_state", {30'b0, state}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
